// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
// Miss-fill sequencer for one 2-way L1 cache instance. On a miss it holds the
// pipeline, issues one block's worth of halfword reads back to back, and writes
// each returned word into the data array. After the last word it raises a
// single-cycle tag/valid commit.
//
// Optional feature: define CACHE_FILL_TIMEOUT_EN to add a FILL watchdog
// (parameter TIMEOUT) and a sticky fill_error output.
module cache_fill_fsm #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
`ifdef CACHE_FILL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] cache_word_address,
  output logic              write_tag_array,
  output logic              fill_done
`ifdef CACHE_FILL_TIMEOUT_EN
  ,
  output logic              fill_error
`endif
);

  // Counters run 0..WORDS, so they need one bit more than a word index.
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  // Clears the byte offset within a block (WORDS halfwords = 2*WORDS bytes).
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((2 * WORDS) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W-1:0]   base_r;
  logic [CNT_W-1:0]    issue_cnt_r;
  logic [CNT_W-1:0]    recv_cnt_r;
  logic                capture_s;
  logic                issue_s;
  logic                recv_s;

  // Byte offset of halfword number cnt inside the block.
  function automatic logic [ADDR_W-1:0] word_offset(input logic [CNT_W-1:0] cnt);
    return {{(ADDR_W - CNT_W - 1){1'b0}}, cnt, 1'b0};
  endfunction

  assign capture_s = (state_r == IDLE) && miss_detected;
  assign issue_s   = (state_r == FILL) && (issue_cnt_r < CNT_FULL);
  assign recv_s    = (state_r == FILL) && memory_data_valid && (recv_cnt_r < CNT_FULL);

`ifdef CACHE_FILL_TIMEOUT_EN
  logic [7:0] wd_r;
  logic       fill_error_r;
  logic       timeout_s;

  // Watchdog trips after TIMEOUT consecutive FILL cycles without an accepted word.
  assign timeout_s  = (state_r == FILL) && !recv_s && (wd_r == 8'(TIMEOUT - 1));
  assign fill_error = fill_error_r;

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r         <= 8'd0;
      fill_error_r <= 1'b0;
    end else begin
      if (capture_s || recv_s) begin
        wd_r <= 8'd0;
      end else if (state_r == FILL) begin
        wd_r <= wd_r + 8'd1;
      end
      if (timeout_s) begin
        fill_error_r <= 1'b1;
      end
    end
  end
`endif

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (miss_detected) state_nxt_s = FILL;
        else               state_nxt_s = IDLE;
      end
      FILL: begin
        if (recv_s && (recv_cnt_r == CNT_LAST)) state_nxt_s = COMMIT;
`ifdef CACHE_FILL_TIMEOUT_EN
        else if (timeout_s)                     state_nxt_s = IDLE;
`endif
        else                                    state_nxt_s = FILL;
      end
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, block base and issue/receive counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      base_r      <= '0;
      issue_cnt_r <= '0;
      recv_cnt_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        base_r      <= miss_address & BLOCK_MASK;
        issue_cnt_r <= '0;
        recv_cnt_r  <= '0;
      end else begin
        if (issue_s) issue_cnt_r <= issue_cnt_r + CNT_ONE;
        if (recv_s)  recv_cnt_r  <= recv_cnt_r + CNT_ONE;
      end
    end
  end

  // Output decode from state and counters; write enable follows valid directly.
  always_comb begin
    fsm_busy           = 1'b0;
    memory_read_en     = 1'b0;
    memory_address     = '0;
    write_data_array   = 1'b0;
    cache_word_address = '0;
    write_tag_array    = 1'b0;
    fill_done          = 1'b0;
    if (state_r != IDLE) fsm_busy = 1'b1;
    else                 fsm_busy = 1'b0;
    if (issue_s) begin
      memory_read_en = 1'b1;
      memory_address = base_r | word_offset(issue_cnt_r);
    end else begin
      memory_read_en = 1'b0;
    end
    if (recv_s) begin
      write_data_array   = 1'b1;
      cache_word_address = base_r | word_offset(recv_cnt_r);
    end else begin
      write_data_array = 1'b0;
    end
    if (state_r == COMMIT) begin
      write_tag_array = 1'b1;
      fill_done       = 1'b1;
    end else begin
      write_tag_array = 1'b0;
      fill_done       = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm. A queue-based model holds the read and
// write addresses still owed for the current fill; a small memory emulator
// returns valids in issue order with configurable latency, gating and noise.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [15:0] cache_word_address;
  logic        write_tag_array;
  logic        fill_done;
`ifdef CACHE_FILL_TIMEOUT_EN
  logic        fill_error;
`endif

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .miss_detected      (miss_detected),
    .miss_address       (miss_address),
    .memory_data_valid  (memory_data_valid),
    .fsm_busy           (fsm_busy),
    .memory_read_en     (memory_read_en),
    .memory_address     (memory_address),
    .write_data_array   (write_data_array),
    .cache_word_address (cache_word_address),
    .write_tag_array    (write_tag_array),
`ifdef CACHE_FILL_TIMEOUT_EN
    .fill_done          (fill_done),
    .fill_error         (fill_error)
`else
    .fill_done          (fill_done)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // model: busy flag, commit cycle flag, addresses still to be read / written
  bit          m_busy = 1'b0;
  bit          m_commit = 1'b0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  int          ret_q[$];

  // stimulus knobs
  int lat_min = 4;
  int lat_max = 4;
  int gate_mode = 0;
  int spur_pct = 0;

  // per-fill observations of the DUT, used for literal checks
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];
  int          rd_cyc[$];
  int          busy_cnt;
  int          tag_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_rd_en"}, memory_read_en, 0);
    chk({tag, "_maddr"}, memory_address, 0);
    chk({tag, "_wr_en"}, write_data_array, 0);
    chk({tag, "_caddr"}, cache_word_address, 0);
    chk({tag, "_tag"}, write_tag_array, 0);
    chk({tag, "_done"}, fill_done, 0);
`ifdef CACHE_FILL_TIMEOUT_EN
    chk({tag, "_err"}, fill_error, 0);
`endif
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, advance the model.
  task automatic step(input logic miss, input logic [15:0] addr);
    logic        e_rd, e_wr, pend, gate, valid;
    logic [15:0] e_maddr, e_caddr, base;
    e_rd    = m_busy && !m_commit && (rd_q.size() > 0);
    e_maddr = e_rd ? rd_q[0] : 16'h0000;
    pend    = (ret_q.size() > 0) && (ret_q[0] <= cyc);
    case (gate_mode)
      0:       gate = 1'b1;
      1:       gate = ((cyc % 2) == 0);
      default: gate = ($urandom_range(1, 0) == 1);
    endcase
    valid = (pend && gate) || ($urandom_range(99, 0) < spur_pct);
    if (pend && gate) void'(ret_q.pop_front());
    e_wr    = m_busy && !m_commit && valid && (wr_q.size() > 0);
    e_caddr = e_wr ? wr_q[0] : 16'h0000;

    miss_detected     = miss;
    miss_address      = addr;
    memory_data_valid = valid;
    #2;
    chk("busy", fsm_busy, m_busy);
    chk("rd_en", memory_read_en, e_rd);
    chk("maddr", memory_address, e_maddr);
    chk("wr_en", write_data_array, e_wr);
    chk("caddr", cache_word_address, e_caddr);
    chk("tag", write_tag_array, m_commit);
    chk("done", fill_done, m_commit);
`ifdef CACHE_FILL_TIMEOUT_EN
    chk("err", fill_error, 0);
`endif
    if (memory_read_en) begin
      rd_log.push_back(memory_address);
      rd_cyc.push_back(cyc);
    end
    if (write_data_array) wr_log.push_back(cache_word_address);
    if (fsm_busy) busy_cnt++;
    if (write_tag_array) tag_cnt++;

    if (!m_busy) begin
      if (miss) begin
        m_busy = 1'b1;
        base   = addr & 16'hFFF0;
        rd_q.delete();
        wr_q.delete();
        for (int i = 0; i < 8; i++) begin
          rd_q.push_back(base + 16'(2 * i));
          wr_q.push_back(base + 16'(2 * i));
        end
      end
    end else if (m_commit) begin
      m_busy   = 1'b0;
      m_commit = 1'b0;
    end else begin
      if (e_rd) begin
        void'(rd_q.pop_front());
        ret_q.push_back(cyc + $urandom_range(lat_max, lat_min));
      end
      if (e_wr) begin
        void'(wr_q.pop_front());
        if (wr_q.size() == 0) begin
          m_commit = 1'b1;
          rd_q.delete();
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // Assert reset mid-cycle with valid still high; everything must drop at once.
  task automatic do_reset();
    memory_data_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    chk_all_zero("rst_mid");
    m_busy   = 1'b0;
    m_commit = 1'b0;
    rd_q.delete();
    wr_q.delete();
    ret_q.delete();
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    @(negedge clk);
    cyc++;
    chk("rst_hold_busy", fsm_busy, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_fill(input logic [15:0] addr, input int abort_at, input bit junk_miss,
                          input bit commit_miss, input logic [15:0] next_addr);
    int n;
    rd_log.delete();
    wr_log.delete();
    rd_cyc.delete();
    busy_cnt = 0;
    tag_cnt  = 0;
    step(1'b1, addr);
    n = 0;
    while (m_busy && n < 400) begin
      if (abort_at >= 0 && !m_commit && (8 - wr_q.size()) == abort_at) begin
        do_reset();
        break;
      end
      if (m_commit && commit_miss) step(1'b1, next_addr);
      else if (junk_miss)          step(1'b1, 16'hFFFE);
      else                         step(1'b0, addr);
      n++;
    end
    if (m_busy) begin
      checks++;
      failures++;
      $display("FAIL fill_bound cycle=%0d actual=still_busy expected=idle", cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    miss_detected = 1'b0;
    miss_address = 16'h0000;
    memory_data_valid = 1'b0;
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    chk_all_zero("post_reset");

    // nominal fill, fixed 4-cycle latency
    run_fill(16'h1236, -1, 1'b0, 1'b0, 16'h0000);
    chk("nom_reads", rd_log.size(), 8);
    chk("nom_writes", wr_log.size(), 8);
    for (int i = 0; i < rd_log.size(); i++) chk("nom_rd_addr", rd_log[i], 32'h1230 + 2 * i);
    for (int i = 0; i < wr_log.size(); i++) chk("nom_wr_addr", wr_log[i], 32'h1230 + 2 * i);
    if (rd_cyc.size() == 8) chk("nom_rd_span", rd_cyc[7] - rd_cyc[0], 7);
    chk("nom_tag_pulses", tag_cnt, 1);
    chk("nom_busy_cycles", busy_cnt, 13);

    // valid in IDLE must not write
    spur_pct = 100;
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000);
    spur_pct = 0;

    // gapped returns: valid only on even cycles
    gate_mode = 1;
    run_fill(16'hABC8, -1, 1'b0, 1'b0, 16'h0000);
    chk("gap_writes", wr_log.size(), 8);
    for (int i = 0; i < wr_log.size(); i++) chk("gap_wr_addr", wr_log[i], 32'hABC0 + 2 * i);
    chk("gap_tag_pulses", tag_cnt, 1);
    gate_mode = 0;

    // spurious valids and a miss to 0xFFFE during the fill
    spur_pct = 30;
    run_fill(16'h4567, -1, 1'b1, 1'b0, 16'h0000);
    chk("spur_writes", wr_log.size(), 8);
    for (int i = 0; i < wr_log.size(); i++) chk("spur_wr_addr", wr_log[i], 32'h4560 + 2 * i);
    chk("spur_tag_pulses", tag_cnt, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000);
    spur_pct = 0;

    // back to back: miss held through COMMIT, accepted the cycle after fill_done
    run_fill(16'h2000, -1, 1'b0, 1'b1, 16'h3456);
    chk("b2b_first_tag", tag_cnt, 1);
    run_fill(16'h3456, -1, 1'b0, 1'b0, 16'h0000);
    chk("b2b_reads", rd_log.size(), 8);
    if (rd_log.size() > 0) chk("b2b_first_rd", rd_log[0], 32'h3450);
    chk("b2b_tag", tag_cnt, 1);

    // reset with three words received, then recovery
    run_fill(16'h7778, 3, 1'b0, 1'b0, 16'h0000);
    chk("abort_writes", wr_log.size(), 3);
    chk("abort_tag", tag_cnt, 0);
    run_fill(16'h7778, -1, 1'b0, 1'b0, 16'h0000);
    chk("recover_tag", tag_cnt, 1);

    // randomized fills
    for (int k = 0; k < 20; k++) begin
      lat_min   = $urandom_range(3, 1);
      lat_max   = lat_min + $urandom_range(4, 0);
      gate_mode = $urandom_range(2, 0);
      spur_pct  = $urandom_range(20, 0);
      run_fill(16'($urandom), -1, ($urandom_range(1, 0) == 1), ($urandom_range(1, 0) == 1),
               16'($urandom));
      chk("rand_writes", wr_log.size(), 8);
      chk("rand_tag", tag_cnt, 1);
      for (int i = 0; i < $urandom_range(3, 0); i++) step(1'b0, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
